dmni_br_svc_rx: RTL and testbench

DMNI_BR_SVC_RX -- requirements
Module: dmni_br_svc_rx

---
 rtl/dmni_br_svc_rx_pkg.sv | 27 ++
 rtl/ring_fifo.sv | 84 ++++++++
 rtl/dmni_br_svc_rx.sv | 70 +++++++
 tb/tb_dmni_br_svc_rx.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dmni_br_svc_rx_pkg.sv
// -----------------------------------------------------------------------------
// DMNIPkg -- shared DMNI definitions used by the BrLite service receive path.
//
// Contents:
//   brlite_svc_t       72-bit BrLite service packet {payload, seq_source,
//                      producer, ksvc}
//   DMNI_BR_SVC_*      memory-mapped register indices of the service FIFO
//   BR_SVC_BUFSIZE     default service-FIFO depth (entries, power of two)
// -----------------------------------------------------------------------------
package DMNIPkg;

    typedef struct packed {
        logic [31:0] payload;
        logic [15:0] seq_source;
        logic [15:0] producer;
        logic [7:0]  ksvc;
    } brlite_svc_t;

    // MMR indices of the service-FIFO register window.
    localparam logic [7:0] DMNI_BR_SVC_KSVC     = 8'h10;
    localparam logic [7:0] DMNI_BR_SVC_PRODUCER = 8'h11;
    localparam logic [7:0] DMNI_BR_SVC_PAYLOAD  = 8'h12;
    localparam logic [7:0] DMNI_BR_SVC_POP      = 8'h13;

    localparam int BR_SVC_BUFSIZE = 8;

endpackage : DMNIPkg

// File: rtl/ring_fifo.sv
// -----------------------------------------------------------------------------
// ring_fifo -- generic circular FIFO with free-running wrapping pointers and a
// separate occupancy counter (so full and empty are unambiguous).
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   push_i            write request; ignored while full
//   wdata_i [WIDTH]   data written at the write pointer on a push
//   pop_i             read request; ignored while empty
//   rdata_o [WIDTH]   entry at the read pointer (undefined content when empty)
//   count_o [CW]      number of stored entries, 0..DEPTH
//   full_o, empty_o   occupancy flags, decoded from registered count only
// -----------------------------------------------------------------------------
module ring_fifo #(
    parameter  int WIDTH = 72,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

    // Gating uses pre-edge flags: a pop while full does not free a slot for a
    // push in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i  && !empty_o;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are exactly AW bits, so +1 wraps modulo DEPTH by itself.
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; after reset the count is zero, so
    // stale contents are never observable and need not be cleared.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule : ring_fifo

// File: rtl/dmni_br_svc_rx.sv
// -----------------------------------------------------------------------------
// dmni_br_svc_rx -- receive buffer for BrLite service packets. Packets offered
// by the router are queued in arrival order; the CPU reads the head entry
// through the DMNI_BR_SVC_* registers and retires it with a write to
// DMNI_BR_SVC_POP. A level interrupt is raised while anything is queued.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   br_req_i, br_data_i  router offers a packet (brlite_svc_t)
//   br_ack_o             packet accepted this cycle (= not full)
//   pop_i                one-cycle pulse retiring the head entry
//   svc_ksvc_o, svc_producer_o, svc_payload_o, svc_source_o
//                        head-entry fields, all zero while empty
//   svc_count_o          number of buffered entries
//   irq_o                high while the buffer is non-empty
// -----------------------------------------------------------------------------
module dmni_br_svc_rx
    import DMNIPkg::*;
#(
    parameter  int BR_SVC_BUFSIZE = DMNIPkg::BR_SVC_BUFSIZE,
    localparam int CW             = $clog2(BR_SVC_BUFSIZE) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          br_req_i,
    input  brlite_svc_t   br_data_i,
    output logic          br_ack_o,
    input  logic          pop_i,
    output logic [7:0]    svc_ksvc_o,
    output logic [15:0]   svc_producer_o,
    output logic [31:0]   svc_payload_o,
    output logic [15:0]   svc_source_o,
    output logic [CW-1:0] svc_count_o,
    output logic          irq_o
);

    localparam int W = $bits(brlite_svc_t);

    logic [W-1:0] rdata;
    logic         full, empty;
    brlite_svc_t  head;

    ring_fifo #(
        .WIDTH (W),
        .DEPTH (BR_SVC_BUFSIZE)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (br_req_i),
        .wdata_i (br_data_i),
        .pop_i   (pop_i),
        .rdata_o (rdata),
        .count_o (svc_count_o),
        .full_o  (full),
        .empty_o (empty)
    );

    // Ack depends only on the registered count, never on req or pop.
    assign br_ack_o = !full;
    assign irq_o    = !empty;

    // Mask the head so stale storage never leaks out while empty.
    assign head = empty ? '0 : brlite_svc_t'(rdata);

    assign svc_ksvc_o     = head.ksvc;
    assign svc_producer_o = head.producer;
    assign svc_payload_o  = head.payload;
    assign svc_source_o   = head.seq_source;

endmodule : dmni_br_svc_rx

// File: tb/tb_dmni_br_svc_rx.sv
module tb_dmni_br_svc_rx;
    import DMNIPkg::*;

    localparam int N  = 8;
    localparam int CW = $clog2(N) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          br_req = 1'b0;
    brlite_svc_t   br_data = '0;
    logic          br_ack;
    logic          pop = 1'b0;
    logic [7:0]    svc_ksvc;
    logic [15:0]   svc_producer;
    logic [31:0]   svc_payload;
    logic [15:0]   svc_source;
    logic [CW-1:0] svc_count;
    logic          irq;

    int checks = 0;
    int errors = 0;

    dmni_br_svc_rx #(.BR_SVC_BUFSIZE(N)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .br_req_i       (br_req),
        .br_data_i      (br_data),
        .br_ack_o       (br_ack),
        .pop_i          (pop),
        .svc_ksvc_o     (svc_ksvc),
        .svc_producer_o (svc_producer),
        .svc_payload_o  (svc_payload),
        .svc_source_o   (svc_source),
        .svc_count_o    (svc_count),
        .irq_o          (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of packets in arrival order.
    brlite_svc_t model_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_q.delete();
        end else begin
            bit do_push, do_pop;
            do_push = br_req && (model_q.size() < N);
            do_pop  = pop && (model_q.size() > 0);
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(br_data);
        end
    end

    function automatic brlite_svc_t model_head();
        return (model_q.size() > 0) ? model_q[0] : brlite_svc_t'('0);
    endfunction

    // Every-cycle comparison on the inactive edge.
    always @(negedge clk) begin
        if (rst_n) begin
            check("ack",   72'(br_ack), 72'(model_q.size() < N));
            check("count", 72'(svc_count), 72'(model_q.size()));
            check("irq",   72'(irq), 72'(model_q.size() != 0));
            check("head",  {svc_payload, svc_source, svc_producer, svc_ksvc}, 72'(model_head()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic brlite_svc_t mk(input logic [31:0] p);
        brlite_svc_t s;
        s.payload    = p;
        s.seq_source = 16'($urandom);
        s.producer   = 16'($urandom);
        s.ksvc       = 8'($urandom);
        return s;
    endfunction

    logic [31:0] pl;

    initial begin
        #12;
        check("rst_ack",   72'(br_ack), 72'(1));
        check("rst_count", 72'(svc_count), 72'(0));
        check("rst_irq",   72'(irq), 72'(0));
        check("rst_head",  {svc_payload, svc_source, svc_producer, svc_ksvc}, 72'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single push with exact field values.
        br_req = 1'b1;
        br_data = '{payload: 32'hDEADBEEF, seq_source: 16'h0102, producer: 16'h0304, ksvc: 8'h05};
        tick();
        br_req = 1'b0;
        check("p1_irq",      72'(irq), 72'(1));
        check("p1_count",    72'(svc_count), 72'(1));
        check("p1_payload",  72'(svc_payload), 72'(32'hDEADBEEF));
        check("p1_source",   72'(svc_source), 72'(16'h0102));
        check("p1_producer", 72'(svc_producer), 72'(16'h0304));
        check("p1_ksvc",     72'(svc_ksvc), 72'(8'h05));
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("p1_drained", 72'(svc_count), 72'(0));

        // Fill to full with payloads 1..8.
        for (int i = 1; i <= 8; i++) begin
            br_req = 1'b1;
            br_data = mk(32'(i));
            tick();
        end
        check("full_ack",   72'(br_ack), 72'(0));
        check("full_count", 72'(svc_count), 72'(8));
        br_data = mk(32'd9);
        tick();
        check("full_hold_count", 72'(svc_count), 72'(8));
        check("full_hold_head",  72'(svc_payload), 72'(1));

        // Pop from full with req held: no push that cycle, push the next.
        pop = 1'b1;
        tick();
        pop = 1'b0;
        check("fullpop_count", 72'(svc_count), 72'(7));
        check("fullpop_head",  72'(svc_payload), 72'(2));
        tick();
        br_req = 1'b0;
        check("fullpop_refill", 72'(svc_count), 72'(8));

        // Drain down to 3, then 20 simultaneous push+pop cycles across wrap.
        pop = 1'b1;
        repeat (5) tick();
        pop = 1'b0;
        check("to3_count", 72'(svc_count), 72'(3));
        check("to3_head",  72'(svc_payload), 72'(7));
        for (int i = 0; i < 20; i++) begin
            br_req = 1'b1;
            pop = 1'b1;
            br_data = mk(32'(100 + i));
            tick();
            check("pp_count", 72'(svc_count), 72'(3));
        end
        br_req = 1'b0;
        pop = 1'b0;
        check("pp_head", 72'(svc_payload), 72'(117));

        // Drain and pop on empty.
        pop = 1'b1;
        repeat (5) tick();
        pop = 1'b0;
        check("empty_count", 72'(svc_count), 72'(0));
        check("empty_irq",   72'(irq), 72'(0));
        check("empty_head",  {svc_payload, svc_source, svc_producer, svc_ksvc}, 72'(0));

        // Reset with 5 entries buffered, observed between clock edges.
        for (int i = 0; i < 5; i++) begin
            br_req = 1'b1;
            br_data = mk(32'(200 + i));
            tick();
        end
        br_req = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("async_irq",   72'(irq), 72'(0));
        check("async_count", 72'(svc_count), 72'(0));
        check("async_ack",   72'(br_ack), 72'(1));
        check("async_head",  {svc_payload, svc_source, svc_producer, svc_ksvc}, 72'(0));
        #1;
        rst_n = 1'b1;
        br_req = 1'b1;
        br_data = mk(32'h55);
        tick();
        br_req = 1'b0;
        check("post_rst_count", 72'(svc_count), 72'(1));
        check("post_rst_head",  72'(svc_payload), 72'(32'h55));

        // Randomized traffic against the model.
        pl = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            br_req = ($urandom_range(0, 99) < 55);
            pop    = ($urandom_range(0, 99) < 45);
            br_data = mk(pl);
            pl++;
            tick();
        end
        br_req = 1'b0;
        pop = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_dmni_br_svc_rx
